tcp_rx_seq_ctrl: RTL

//  Per-segment sequencer in front of tcp_reorder_buffer. Takes parsed TCP header descriptors plus

---
 rtl/tcp_rx_seq_ctrl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/tcp_rx_seq_ctrl.sv
// Per-segment receive sequencer: validates each TCP segment against the receive window, forwards
// or discards its payload, tracks rcv_nxt, programs the reorder-buffer base on SYN and requests ACKs.
module tcp_rx_seq_ctrl #(
   parameter int unsigned SEQ_BITS = 32,
   parameter int unsigned LEN_BITS = 16,
   parameter int unsigned CNT_BITS = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                hdr_valid,
   output logic                hdr_ready,
   input  logic [SEQ_BITS-1:0] hdr_seq,
   input  logic [LEN_BITS-1:0] hdr_len,
   input  logic                hdr_syn,
   input  logic [7:0]          s_tdata,
   input  logic                s_tvalid,
   input  logic                s_tlast,
   output logic                s_tready,
   output logic [7:0]          rb_tdata,
   output logic                rb_tvalid,
   output logic                rb_tlast,
   input  logic                rb_tready,
   output logic [SEQ_BITS-1:0] rb_seq_start,
   output logic [SEQ_BITS-1:0] rb_seq_base,
   output logic                rb_base_valid,
   input  logic [SEQ_BITS-1:0] rb_window,
   input  logic                dlv_fire,
   output logic                ack_valid,
   input  logic                ack_ready,
   output logic [SEQ_BITS-1:0] ack_seq,
   output logic [SEQ_BITS-1:0] ack_win,
   output logic                synced,
   output logic [SEQ_BITS-1:0] rcv_nxt,
   output logic [CNT_BITS-1:0] drop_cnt
);

   typedef enum logic [2:0] {StIdle, StCheck, StFwd, StDrop, StAck} state_e;

   state_e              state_q, state_d;
   logic [SEQ_BITS-1:0] seq_q, seq_d;
   logic [LEN_BITS-1:0] len_q, len_d;
   logic                syn_q, syn_d;
   logic                synced_q, synced_d;
   logic                drop_ack_q, drop_ack_d;
   logic                alive_q;
   logic [SEQ_BITS-1:0] rcv_nxt_q, rcv_nxt_d;
   logic [CNT_BITS-1:0] drop_cnt_q, drop_cnt_d;
   logic [SEQ_BITS-1:0] seq_start_q, seq_start_d;
   logic [SEQ_BITS-1:0] base_q, base_d;
   logic [SEQ_BITS-1:0] ack_seq_q, ack_seq_d;
   logic [SEQ_BITS-1:0] ack_win_q, ack_win_d;
   logic [SEQ_BITS-1:0] off;
   logic [SEQ_BITS:0]   span;
   logic                fits;
   logic                enter_ack;

   // Offset is taken modulo 2^SEQ_BITS; its MSB marks old/duplicate data.
   assign off  = seq_q - rcv_nxt_q;
   assign span = {1'b0, off} + {{(SEQ_BITS + 1 - LEN_BITS){1'b0}}, len_q};
   assign fits = span <= {1'b0, rb_window};

   always_comb begin
      state_d       = state_q;
      seq_d         = seq_q;
      len_d         = len_q;
      syn_d         = syn_q;
      synced_d      = synced_q;
      drop_ack_d    = drop_ack_q;
      rcv_nxt_d     = rcv_nxt_q;
      drop_cnt_d    = drop_cnt_q;
      seq_start_d   = seq_start_q;
      base_d        = base_q;
      ack_seq_d     = ack_seq_q;
      ack_win_d     = ack_win_q;
      hdr_ready     = 1'b0;
      s_tready      = 1'b0;
      rb_tdata      = 8'h00;
      rb_tvalid     = 1'b0;
      rb_tlast      = 1'b0;
      rb_base_valid = 1'b0;
      ack_valid     = 1'b0;
      enter_ack     = 1'b0;

      if (dlv_fire) rcv_nxt_d = rcv_nxt_q + 1'b1;

      unique case (state_q)
         StIdle: begin
            hdr_ready = alive_q;
            if (hdr_valid && alive_q) begin
               seq_d   = hdr_seq;
               len_d   = hdr_len;
               syn_d   = hdr_syn;
               state_d = StCheck;
            end
         end
         StCheck: begin
            if (syn_q) begin
               // SYN load overrides any same-cycle delivery increment.
               base_d        = seq_q + 1'b1;
               rcv_nxt_d     = seq_q + 1'b1;
               rb_base_valid = 1'b1;
               synced_d      = 1'b1;
               drop_ack_d    = 1'b1;
               state_d       = StDrop;
            end else if (!synced_q || off[SEQ_BITS-1] || !fits) begin
               if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 1'b1;
               drop_ack_d = synced_q;
               state_d    = StDrop;
            end else if (len_q == '0) begin
               enter_ack = 1'b1;
            end else begin
               seq_start_d = seq_q;
               state_d     = StFwd;
            end
         end
         StFwd: begin
            rb_tdata  = s_tdata;
            rb_tvalid = s_tvalid;
            rb_tlast  = s_tlast;
            s_tready  = rb_tready;
            if (s_tvalid && rb_tready && s_tlast) enter_ack = 1'b1;
         end
         StDrop: begin
            s_tready = 1'b1;
            if (len_q == '0 || (s_tvalid && s_tlast)) begin
               if (drop_ack_q) enter_ack = 1'b1;
               else            state_d   = StIdle;
            end
         end
         StAck: begin
            ack_valid = 1'b1;
            if (ack_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      if (enter_ack) begin
         state_d   = StAck;
         ack_seq_d = rcv_nxt_q;
         ack_win_d = rb_window;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         seq_q       <= '0;
         len_q       <= '0;
         syn_q       <= 1'b0;
         synced_q    <= 1'b0;
         drop_ack_q  <= 1'b0;
         alive_q     <= 1'b0;
         rcv_nxt_q   <= '0;
         drop_cnt_q  <= '0;
         seq_start_q <= '0;
         base_q      <= '0;
         ack_seq_q   <= '0;
         ack_win_q   <= '0;
      end else begin
         state_q     <= state_d;
         seq_q       <= seq_d;
         len_q       <= len_d;
         syn_q       <= syn_d;
         synced_q    <= synced_d;
         drop_ack_q  <= drop_ack_d;
         alive_q     <= 1'b1;
         rcv_nxt_q   <= rcv_nxt_d;
         drop_cnt_q  <= drop_cnt_d;
         seq_start_q <= seq_start_d;
         base_q      <= base_d;
         ack_seq_q   <= ack_seq_d;
         ack_win_q   <= ack_win_d;
      end
   end

   // base_d already carries the new base during the SYN check cycle, alongside the pulse.
   assign rb_seq_base  = base_d;
   assign rb_seq_start = seq_start_q;
   assign ack_seq      = ack_seq_q;
   assign ack_win      = ack_win_q;
   assign synced       = synced_q;
   assign rcv_nxt      = rcv_nxt_q;
   assign drop_cnt     = drop_cnt_q;

endmodule
